// File: rtl/ir_key_dispatcher.sv
// ir_key_dispatcher: queues debounced key presses, turns each into a command
// word for the IR encoder, and issues repeat requests while the key is held.
module ir_key_dispatcher #(
  parameter int NUM_KEYS      = 4,
  parameter int CMD_W         = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 2700000,
  parameter int REPEAT_PERIOD = 2700000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_KEYS-1:0]       key_pressed,
  input  logic [NUM_KEYS-1:0]       key_state,
  input  logic [NUM_KEYS*CMD_W-1:0] cmd_table,
  output logic [CMD_W-1:0]          cmd,
  output logic                      cmd_repeat,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      overflow,
  output logic                      busy
);

  localparam int KW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNTW  = PW + 1;
  localparam int MAXR  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW    = (MAXR > 1) ? $clog2(MAXR) : 1;
  localparam logic [CW-1:0]   DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]   PER_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CNTW-1:0] DEPTH_V  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, RPT} state_t;

  state_t          state;
  logic [KW-1:0]   key_r;
  logic [CW-1:0]   cnt;
  logic            abort_r;

  logic [KW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] fifo_cnt;
  logic [CNTW-1:0] fifo_cnt_n;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_nonempty_n;
  logic            any_press;
  logic            multi_press;
  logic            push;
  logic            pop;
  logic            held;
  logic            leave;
  logic [KW-1:0]   press_idx;
  logic [KW-1:0]   head_key;

  // Lowest set bit wins when several keys pulse in the same cycle.
  function automatic logic [KW-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = KW'(i);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    sat_inc = (&c) ? c : c + CW'(1);
  endfunction

  // Queue status, push/pop decisions and hold/release conditions.
  always_comb begin
    fifo_empty      = (fifo_cnt == '0);
    fifo_full       = (fifo_cnt == DEPTH_V);
    any_press       = |key_pressed;
    multi_press     = |(key_pressed & (key_pressed - NUM_KEYS'(1)));
    press_idx       = lowest_idx(key_pressed);
    head_key        = fifo_mem[rd_ptr];
    pop             = (state == IDLE) && !fifo_empty;
    push            = any_press && (!fifo_full || pop);
    fifo_cnt_n      = fifo_cnt + CNTW'(push) - CNTW'(pop);
    fifo_nonempty_n = (fifo_cnt_n != '0);
    held            = key_state[key_r];
    leave           = !held || !fifo_empty;
  end

  // Queue pointers, occupancy and the sticky lost-press flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt_n;
      if (multi_press || (any_press && !push)) overflow <= 1'b1;
    end
  end

  // Queue storage; entries need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr] <= press_idx;
  end

  // Dispatch FSM: send a frame, then time the hold and issue repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_r      <= '0;
      cnt        <= '0;
      abort_r    <= 1'b0;
      cmd        <= '0;
      cmd_repeat <= 1'b0;
      cmd_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            cmd        <= cmd_table[int'(head_key)*CMD_W +: CMD_W];
            cmd_repeat <= 1'b0;
            cmd_valid  <= 1'b1;
            key_r      <= head_key;
            state      <= SEND;
          end else begin
            busy <= fifo_nonempty_n;
          end
        end
        SEND: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            cnt       <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (leave) begin
            state <= IDLE;
            busy  <= fifo_nonempty_n;
          end else if (cnt == DLY_LAST) begin
            cmd_valid  <= 1'b1;
            cmd_repeat <= 1'b1;
            abort_r    <= 1'b0;
            state      <= RPT;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RPT: begin
          if (cmd_valid) begin
            // A pending repeat always completes; an abort only takes effect after it.
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              cnt       <= '0;
              abort_r   <= 1'b0;
              if (abort_r || leave) begin
                state <= IDLE;
                busy  <= fifo_nonempty_n;
              end
            end else if (leave) begin
              abort_r <= 1'b1;
            end
          end else if (leave) begin
            state <= IDLE;
            busy  <= fifo_nonempty_n;
          end else if (cnt == PER_LAST) begin
            cmd_valid  <= 1'b1;
            cmd_repeat <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_key_dispatcher.sv
// Scoreboard bench for ir_key_dispatcher: stimulus pushes expected frames,
// a negedge monitor pops and compares on each valid/ready transfer.
module tb_ir_key_dispatcher;

  localparam int NK = 4;
  localparam int CW = 32;
  localparam int FD = 4;
  localparam int RD = 100;
  localparam int RP = 50;
  localparam int HOLD_CYC = 300;

  logic             clk = 1'b0;
  logic             rst;
  logic [NK-1:0]    key_pressed;
  logic [NK-1:0]    key_state;
  logic [NK*CW-1:0] cmd_table;
  logic [CW-1:0]    cmd;
  logic             cmd_repeat;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             overflow;
  logic             busy;

  typedef struct packed {
    logic [CW-1:0] c;
    logic          r;
  } exp_t;

  exp_t sb[$];
  int   xfer_t[$];
  int   checks     = 0;
  int   errors     = 0;
  int   xfer_cnt   = 0;
  int   cyc        = 0;
  int   ready_mode = 1;

  always #5 clk = ~clk;

  ir_key_dispatcher #(
    .NUM_KEYS(NK), .CMD_W(CW), .FIFO_DEPTH(FD),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .key_pressed(key_pressed), .key_state(key_state),
    .cmd_table(cmd_table), .cmd(cmd), .cmd_repeat(cmd_repeat),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .overflow(overflow), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] tslot(input int k);
    return cmd_table[k*CW +: CW];
  endfunction

  function automatic exp_t mk(input logic [CW-1:0] c, input logic r);
    exp_t e;
    e.c = c;
    e.r = r;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  // Encoder-side ready: held low, held high, or random per cycle.
  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cmd_ready = 1'b0;
        1:       cmd_ready = 1'b1;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a transfer happens at the next posedge when valid and ready are both high now.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
        xfer_cnt++;
        xfer_t.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer actual cmd=%h rpt=%b required no transfer", cmd, cmd_repeat);
        end else begin
          e = sb.pop_front();
          chk("xfer_rpt", 64'(cmd_repeat), 64'(e.r));
          if (!e.r) chk("xfer_cmd", 64'(cmd), 64'(e.c));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  // Pulse a press mask for one cycle, holding those keys for 'cycles' cycles.
  task automatic press_hold(input logic [NK-1:0] mask, input int cycles);
    @(posedge clk);
    #1;
    key_pressed = mask;
    key_state   = key_state | mask;
    @(posedge clk);
    #1;
    key_pressed = '0;
    if (cycles > 1) begin
      repeat (cycles - 1) @(posedge clk);
      #1;
    end
    key_state = key_state & ~mask;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while ((busy || cmd_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy || cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL %s actual busy=%b valid=%b required idle within %0d cycles", nm, busy, cmd_valid, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (!cmd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL %s actual valid=0 required valid within %0d cycles", nm, budget);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int lowest_key(input logic [NK-1:0] m);
    for (int i = 0; i < NK; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  initial begin
    int base;
    int t0;
    int n;
    int nrep;
    int k;
    logic [NK-1:0] m;

    rst         = 1'b1;
    key_pressed = '0;
    key_state   = '0;
    for (int i = 0; i < NK; i++) cmd_table[i*CW +: CW] = $urandom;
    cmd_table[1*CW +: CW] = 32'h9F600707;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", 64'(cmd), 64'(0));
    chk("rst_rpt", 64'(cmd_repeat), 64'(0));
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single press of key 1, held 10 cycles
    base = xfer_cnt;
    sb.push_back(mk(32'h9F600707, 1'b0));
    press_hold(4'b0010, 10);
    wait_idle(200, "single_idle");
    chk("single_count", 64'(xfer_cnt - base), 64'(1));
    chk("single_busy", 64'(busy), 64'(0));
    chk("single_ovf", 64'(overflow), 64'(0));

    // Backpressure: 20 cycles of cmd_ready low
    ready_mode = 0;
    repeat (2) @(posedge clk);
    base = xfer_cnt;
    sb.push_back(mk(tslot(3), 1'b0));
    press_hold(4'b1000, 1);
    wait_valid(20, "bp_valid");
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_valid", 64'(cmd_valid), 64'(1));
      chk("bp_hold_cmd", 64'(cmd), 64'(tslot(3)));
      @(negedge clk);
    end
    chk("bp_no_xfer", 64'(xfer_cnt - base), 64'(0));
    ready_mode = 1;
    wait_idle(100, "bp_idle");
    chk("bp_count", 64'(xfer_cnt - base), 64'(1));

    // Auto-repeat: key 2 held for HOLD_CYC cycles
    base = xfer_cnt;
    t0   = xfer_t.size();
    sb.push_back(mk(tslot(2), 1'b0));
    nrep = 0;
    for (int t = RD; t < HOLD_CYC; t += RP) begin
      sb.push_back(mk(tslot(2), 1'b1));
      nrep++;
    end
    press_hold(4'b0100, HOLD_CYC);
    @(posedge clk);
    @(negedge clk);
    chk("rpt_release_busy", 64'(busy), 64'(0));
    chk("rpt_release_valid", 64'(cmd_valid), 64'(0));
    chk("rpt_count", 64'(xfer_cnt - base), 64'(1 + nrep));
    for (int i = 1; i <= nrep && (t0 + i) < xfer_t.size(); i++) begin
      n = xfer_t[t0 + i] - xfer_t[t0 + i - 1];
      chk("rpt_gap_ok", 64'((n >= ((i == 1) ? RD : RP) - 3) && (n <= ((i == 1) ? RD : RP) + 5)), 64'(1));
    end

    // Pre-emption: key 0 repeating, key 3 pressed
    base = xfer_cnt;
    sb.push_back(mk(tslot(0), 1'b0));
    sb.push_back(mk(tslot(0), 1'b1));
    @(posedge clk);
    #1;
    key_pressed = 4'b0001;
    key_state   = 4'b0001;
    @(posedge clk);
    #1;
    key_pressed = '0;
    n = 0;
    while (xfer_cnt < base + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("pre_first_rpt_seen", 64'(xfer_cnt >= base + 2), 64'(1));
    repeat (10) @(posedge clk);
    sb.push_back(mk(tslot(3), 1'b0));
    press_hold(4'b1000, 1);
    repeat (150) @(posedge clk);
    #1;
    key_state = '0;
    wait_idle(100, "pre_idle");
    chk("pre_count", 64'(xfer_cnt - base), 64'(3));

    // Simultaneous presses: only key 1 sent, overflow set
    chk("sim_ovf_before", 64'(overflow), 64'(0));
    base = xfer_cnt;
    sb.push_back(mk(tslot(1), 1'b0));
    press_hold(4'b1010, 1);
    wait_idle(100, "sim_idle");
    chk("sim_count", 64'(xfer_cnt - base), 64'(1));
    chk("sim_ovf", 64'(overflow), 64'(1));

    // FIFO overflow: FD+2 presses while the encoder stalls
    do_reset(1);
    @(negedge clk);
    chk("fifo_ovf_cleared", 64'(overflow), 64'(0));
    ready_mode = 0;
    repeat (2) @(posedge clk);
    base = xfer_cnt;
    for (int i = 0; i < FD + 2; i++) begin
      k = $urandom_range(0, NK - 1);
      if (i < FD + 1) sb.push_back(mk(tslot(k), 1'b0));
      press_hold(NK'(1) << k, 1);
    end
    @(negedge clk);
    chk("fifo_ovf", 64'(overflow), 64'(1));
    ready_mode = 1;
    wait_idle(300, "fifo_idle");
    chk("fifo_count", 64'(xfer_cnt - base), 64'(FD + 1));

    // Reset while cmd_valid is high; a press during reset is ignored
    ready_mode = 0;
    repeat (2) @(posedge clk);
    sb.push_back(mk(tslot(2), 1'b0));
    press_hold(4'b0100, 1);
    wait_valid(20, "mid_valid");
    @(posedge clk);
    #1;
    rst         = 1'b1;
    key_pressed = 4'b0001;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    key_pressed = '0;
    @(negedge clk);
    chk("mid_cmd", 64'(cmd), 64'(0));
    chk("mid_rpt", 64'(cmd_repeat), 64'(0));
    chk("mid_valid", 64'(cmd_valid), 64'(0));
    chk("mid_ovf", 64'(overflow), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    void'(sb.pop_back());
    base = xfer_cnt;
    ready_mode = 1;
    repeat (20) @(negedge clk);
    chk("mid_no_xfer", 64'(xfer_cnt - base), 64'(0));
    chk("mid_still_idle", 64'(busy), 64'(0));

    // Randomized presses with random backpressure
    ready_mode = 2;
    for (int it = 0; it < 16; it++) begin
      m = NK'($urandom_range(1, (1 << NK) - 1));
      base = xfer_cnt;
      sb.push_back(mk(tslot(lowest_key(m)), 1'b0));
      press_hold(m, $urandom_range(1, 30));
      wait_idle(300, "rand_idle");
      chk("rand_count", 64'(xfer_cnt - base), 64'(1));
    end
    ready_mode = 1;

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_key_dispatcher.md
IR_KEY_DISPATCHER -- requirements
Module: ir_key_dispatcher

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of key channels, range 1..16.
REQ-002 SHALL have parameter CMD_W, default 32: command word width per key.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: press-event queue depth, a power of 2 and at least 2.
REQ-004 SHALL have parameter REPEAT_DELAY, default 2700000: hold cycles after a frame is accepted before the first repeat.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 2700000: cycles between repeats; must be at least 1.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port key_pressed, input, NUM_KEYS: one-cycle press pulses from the debouncers.
REQ-009 SHALL have port key_state, input, NUM_KEYS: debounced level, 1 = held.
REQ-010 SHALL have port cmd_table, input, NUM_KEYS*CMD_W: key i command is bits [i*CMD_W +: CMD_W]; treated as static.
REQ-011 SHALL have port cmd, output, CMD_W: command presented to the encoder.
REQ-012 SHALL have port cmd_repeat, output, 1: 1 = send a repeat frame; cmd value then don't-care.
REQ-013 SHALL have port cmd_valid, output, 1: cmd/cmd_repeat valid.
REQ-014 SHALL have port cmd_ready, input, 1: encoder can accept.
REQ-015 SHALL have port overflow, output, 1: sticky; set when a press event is lost.
REQ-016 SHALL have port busy, output, 1: 1 whenever state is not IDLE or the FIFO is not empty.

Function
REQ-017 SHALL register every output; clk is the only clock.
REQ-018 SHALL, on each cycle with any key_pressed bit high, enqueue only the lowest set index; any other set bits in that cycle are dropped and set overflow.
REQ-019 SHALL drop a press arriving while the FIFO is full and set overflow; when a pop and a push occur in the same cycle on a full FIFO, both proceed.
REQ-020 SHALL use the FIFO pointer wrap at FIFO_DEPTH with no loss of order, so that events pop in arrival order.
REQ-021 SHALL implement states IDLE, SEND, HOLD and RPT.
REQ-022 SHALL, in IDLE with the FIFO non-empty, pop the head key k, load cmd from table slot k, clear cmd_repeat, assert cmd_valid and go to SEND; cmd_valid rises 1 cycle after the pop decision.
REQ-023 SHALL transfer on the rising clk edge where cmd_valid and cmd_ready are both 1.
REQ-024 SHALL hold cmd, cmd_repeat and cmd_valid stable until the transfer, and deassert cmd_valid in the cycle after it.
REQ-025 SHALL, on a non-repeat transfer in SEND, go to HOLD with the hold counter cleared and the active key recorded as k.
REQ-026 SHALL, in HOLD or RPT, return to IDLE in the next cycle when key_state[k] = 0; release takes priority over a timer expiry in the same cycle.
REQ-027 SHALL, in HOLD or RPT, return to IDLE when the FIFO is non-empty, so that a new press pre-empts repeats of the old key.
REQ-028 SHALL, in HOLD, when the counter reaches REPEAT_DELAY-1 with the key still held, assert cmd_valid with cmd_repeat = 1 and go to RPT.
REQ-029 SHALL, in RPT, keep the repeat request pending until transferred, then restart the counter; a repeat request is issued again after REPEAT_PERIOD-1 counts.
REQ-030 SHALL, if a release or a new FIFO event occurs while a repeat request is pending, keep the request pending until transfer, then go to IDLE.
REQ-031 SHALL size the counter to $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) bits and saturate it; it never wraps.

Reset
REQ-032 SHALL, with rst high at a clk edge, set state = IDLE, empty the FIFO and clear counters.
REQ-033 SHALL drive reset values cmd = 0, cmd_repeat = 0, cmd_valid = 0, overflow = 0 and busy = 0.
REQ-034 SHALL, when reset is asserted mid-transfer or mid-hold, abandon the request with no further cmd_valid, and ignore presses during reset.

Verification
REQ-035 Bench SHALL cover single press: NUM_KEYS=4, table slot 1 = 32'h9F600707, cmd_ready=1, key_pressed=4'b0010 pulse, key_state low after 10 cycles -> one cmd_valid with cmd=32'h9F600707 and cmd_repeat=0, then IDLE and busy=0.
REQ-036 Bench SHALL cover backpressure: cmd_ready=0 for 20 cycles -> cmd_valid and cmd held stable for all 20 cycles, exactly one transfer once cmd_ready=1.
REQ-037 Bench SHALL cover auto-repeat: REPEAT_DELAY=100, REPEAT_PERIOD=50, key 2 held 300 cycles -> first frame, then repeats at about +100, +150, +200 and +250, then IDLE within 1 cycle of release.
REQ-038 Bench SHALL cover simultaneous presses and overflow: key_pressed=4'b1010 in one cycle -> key 1 only sent, overflow=1; then FIFO_DEPTH+2 presses while cmd_ready=0 -> exactly FIFO_DEPTH+1 sent in order (1 in the output stage plus FIFO_DEPTH queued).
REQ-039 Bench SHALL cover pre-emption: key 0 held in RPT and key 3 pressed -> no further repeat of key 0, next frame = table slot 3 with cmd_repeat=0.
REQ-040 Bench SHALL cover reset mid-operation: rst for 1 cycle while cmd_valid=1 -> all outputs at reset values next cycle, and no transfer occurs.
